// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, FD pipeline latch and fetch counter.
// Redirect outranks flush/stall; address_imem is a direct tap of the PC.
module fetch_stage (
   input  logic        clock,
   input  logic        reset,
   output logic [11:0] address_imem,
   input  logic [31:0] q_imem,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_out,
   output logic [31:0] fd_insn,
   output logic [31:0] fd_pc,
   output logic        fd_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] r_pc;
   logic [31:0] r_fd_insn;
   logic [31:0] r_fd_pc;
   logic        r_fd_valid;
   logic [31:0] r_count;

   logic [31:0] w_pc_inc;
   logic        w_bubble;
   logic        w_load;

   assign w_pc_inc = r_pc + 32'd1;
   assign w_bubble = redirect_valid | flush;
   assign w_load   = ~w_bubble & ~stall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc <= 32'd0;
      end else if (redirect_valid) begin
         r_pc <= redirect_pc;
      end else if (!stall) begin
         r_pc <= w_pc_inc;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fd_insn  <= 32'd0;
         r_fd_pc    <= 32'd0;
         r_fd_valid <= 1'b0;
         r_count    <= 32'd0;
      end else if (w_bubble) begin
         r_fd_insn  <= 32'd0;
         r_fd_pc    <= 32'd0;
         r_fd_valid <= 1'b0;
      end else if (w_load) begin
         r_fd_insn  <= q_imem;
         r_fd_pc    <= w_pc_inc;
         r_fd_valid <= 1'b1;
         r_count    <= r_count + 32'd1;
      end
   end

   assign address_imem = r_pc[11:0];
   assign pc_out       = r_pc;
   assign fd_insn      = r_fd_insn;
   assign fd_pc        = r_fd_pc;
   assign fd_valid     = r_fd_valid;
   assign fetch_count  = r_count;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; low forces all state to reset values immediately.
REQ-003 address_imem  output  12  instruction memory word address; equals pc_out[11:0].
REQ-004 q_imem  input  32  instruction word at address_imem, valid in the same cycle.
REQ-005 stall  input  1  hazard unit request to hold PC and FD latch.
REQ-006 flush  input  1  squash request; FD latch loads a bubble.
REQ-007 redirect_valid  input  1  taken branch/jump resolved downstream.
REQ-008 redirect_pc  input  32  target PC when redirect_valid is high.
REQ-009 pc_out  output  32  current PC register.
REQ-010 fd_insn  output  32  FD latch instruction; 32'h00000000 (nop) when not valid.
REQ-011 fd_pc  output  32  FD latch PC+1 of the latched instruction.
REQ-012 fd_valid  output  1  FD latch holds a real fetched instruction.
REQ-013 fetch_count  output  32  number of valid instructions latched into FD since reset.

Function
REQ-014 PC is 32-bit, word-addressed; sequential next PC = pc_out + 1, wrapping 32'hFFFFFFFF -> 32'h00000000.
REQ-015 Next-PC priority per edge: redirect_valid -> redirect_pc; else stall -> hold; else pc_out + 1.
REQ-016 FD latch priority per edge: (redirect_valid or flush) -> bubble; else stall -> hold; else load.
REQ-017 Load: fd_insn <= q_imem, fd_pc <= pc_out + 1, fd_valid <= 1.
REQ-018 Bubble: fd_insn <= 0, fd_pc <= 0, fd_valid <= 0.
REQ-019 Hold: fd_insn, fd_pc, fd_valid unchanged.
REQ-020 redirect_valid overrides stall for both PC and FD in the same cycle.
REQ-021 flush with stall, no redirect: PC holds, FD takes bubble.
REQ-022 fetch_count increments by 1 on every edge where a Load occurs; wraps at 2^32; unchanged on Hold/Bubble.
REQ-023 Fetch latency: instruction at PC n appears on fd_insn one edge after pc_out = n, absent stall/flush/redirect.
REQ-024 Stall for k consecutive cycles delays the stream by exactly k cycles; no instruction lost or duplicated.
REQ-025 address_imem is purely combinational from pc_out; no additional register stage.
REQ-026 redirect_pc is used unmodified; upper 20 bits are retained in pc_out though not driven to imem.
REQ-027 Inputs stall/flush/redirect are sampled only at rising clock; glitches between edges have no effect.

Reset
REQ-028 While reset low: pc_out = 0, fd_insn = 0, fd_pc = 0, fd_valid = 0, fetch_count = 0.
REQ-029 Reset assertion mid-operation clears all state asynchronously, regardless of clock or pending stall/redirect.
REQ-030 First edge after reset release with no stall: fd_insn <= imem[0], fd_pc <= 1, fd_valid <= 1, pc_out <= 1, fetch_count <= 1.
REQ-031 Reset deassertion is treated as synchronous to clock by the environment; no internal synchronizer.

Verification
REQ-032 Straight-line: imem[0..3]=A,B,C,D, no control inputs, 4 edges -> fd_insn sequence A,B,C,D; fd_pc 1,2,3,4; fetch_count 4.
REQ-033 Stall: stall high 2 cycles while fd_insn=B, pc_out=2 -> fd_insn stays B, pc_out stays 2, fetch_count frozen; then C follows.
REQ-034 Redirect plus stall: pc_out=5, stall=1, redirect_valid=1, redirect_pc=32'h20 -> next pc_out=32'h20, fd_valid=0, fd_insn=0; next edge fd_insn=imem[32'h20], fd_pc=32'h21.
REQ-035 Flush plus stall: pc_out=7, flush=1, stall=1 -> pc_out stays 7, fd_valid=0; following edge fd_insn=imem[7].
REQ-036 Wrap: redirect_pc=32'hFFFFFFFF, one edge, then free-run -> pc_out goes 32'hFFFFFFFF then 0, address_imem 12'hFFF then 12'h000, fd_pc=0.
REQ-037 Async reset: drive reset low between edges while fd_valid=1, fetch_count=9 -> all outputs zero before next edge; REQ-030 behaviour after release.
